// File: rtl/door_timer_divider_pkg.sv
// door_timer_divider_pkg: shared timer constants, FSM state type and clog2 helper (package timer_pkg, no ports).
package timer_pkg;
    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_TICK_HZ = 1;
    localparam int DOOR_OPEN_TICKS = 10;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/door_timer_divider_tick_prescaler.sv
// tick_prescaler: divides the clock by P into a 50% square wave and a one-cycle tick pulse.
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset (pre_cnt=0, tick_sq=1)
//   clr_i        restart the tick period from phase 0 with tick_sq high
//   tick_sq_o    square wave, high for the first P/2 cycles of each period
//   tick_pulse_o high in the last cycle of each period
module tick_prescaler import timer_pkg::*; #(
    parameter int P = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_sq_o,
    output logic tick_pulse_o
);
    localparam int PW = (clog2(P) < 1) ? 1 : clog2(P);
    localparam logic [PW-1:0] LAST = PW'(P - 1);
    localparam logic [PW-1:0] HALF = PW'(P / 2 - 1);
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic tick_sq_q, tick_sq_d;
    always_comb begin
        pre_cnt_d = clr_i ? '0 : ((pre_cnt_q == LAST) ? '0 : pre_cnt_q + 1'b1);
        // toggle on the edges leaving the half-period and full-period phases
        tick_sq_d = clr_i ? 1'b1 : tick_sq_q ^ ((pre_cnt_q == HALF) || (pre_cnt_q == LAST));
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt_q <= '0;
            tick_sq_q <= 1'b1;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_sq_q <= tick_sq_d;
        end
    end
    assign tick_sq_o = tick_sq_q;
    assign tick_pulse_o = (pre_cnt_q == LAST);
endmodule

// File: rtl/door_timer_divider.sv
// door_timer_divider: tick timebase plus programmable door-open tick countdown.
//   C_100Mhz      system clock, rising edge
//   restart       synchronous active-high reset
//   start         load timeout_ticks (0 treated as 1) and run
//   retrigger     reload latched value while running
//   hold          freeze the countdown; ticks during hold are discarded
//   periodic      auto-reload on expiry instead of going idle
//   ack           clear the sticky expired flag
//   timeout_ticks load value, sampled on start
//   tick_sq/tick_pulse  timebase outputs
//   running/remaining   countdown state
//   expired/expire_pulse sticky flag and one-cycle expiry strobe
//   warn          pre-expiry warning, only built with macro DOOR_WARN_EN
module door_timer_divider import timer_pkg::*; #(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ,
    parameter int CNT_W = 8,
    parameter int WARN_TICKS = 3
) (
    input  logic             C_100Mhz,
    input  logic             restart,
    input  logic             start,
    input  logic             retrigger,
    input  logic             hold,
    input  logic             periodic,
    input  logic             ack,
    input  logic [CNT_W-1:0] timeout_ticks,
    output logic             tick_sq,
    output logic             tick_pulse,
    output logic             running,
    output logic [CNT_W-1:0] remaining,
    output logic             expired,
    output logic             expire_pulse,
    output logic             warn
);
    localparam int P = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    if (P < 2 || P % 2 != 0 || WARN_TICKS < 0) begin : g_bad_cfg
        $error("door_timer_divider: CLK_HZ/TICK_HZ must be even and >= 2, WARN_TICKS >= 0");
    end
    state_t state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d, reload_q, reload_d, load_val;
    logic expired_q, expired_d, expire_pulse_q, expire_pulse_d, pre_clr;
    assign pre_clr = start || (retrigger && state_q == RUN);
    assign load_val = (timeout_ticks == '0) ? ONE : timeout_ticks;
    tick_prescaler #(.P(P)) u_pre (
        .clk_i(C_100Mhz),
        .rst_i(restart),
        .clr_i(pre_clr),
        .tick_sq_o(tick_sq),
        .tick_pulse_o(tick_pulse)
    );
    always_comb begin
        state_d = state_q;
        remaining_d = remaining_q;
        reload_d = reload_q;
        // ack is weakest: start and expiry below overwrite it
        expired_d = ack ? 1'b0 : expired_q;
        expire_pulse_d = 1'b0;
        if (start) begin
            reload_d = load_val;
            remaining_d = load_val;
            state_d = RUN;
            expired_d = 1'b0;
        end else if (state_q == RUN && retrigger) begin
            remaining_d = reload_q;
        end else if (state_q == RUN && tick_pulse && !hold) begin
            if (remaining_q > ONE) begin
                remaining_d = remaining_q - 1'b1;
            end else begin
                expire_pulse_d = 1'b1;
                expired_d = 1'b1;
                remaining_d = periodic ? reload_q : '0;
                state_d = periodic ? RUN : IDLE;
            end
        end
    end
    always_ff @(posedge C_100Mhz) begin
        if (restart) begin
            state_q <= IDLE;
            remaining_q <= '0;
            reload_q <= '0;
            expired_q <= 1'b0;
            expire_pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            remaining_q <= remaining_d;
            reload_q <= reload_d;
            expired_q <= expired_d;
            expire_pulse_q <= expire_pulse_d;
        end
    end
    assign running = (state_q == RUN);
    assign remaining = remaining_q;
    assign expired = expired_q;
    assign expire_pulse = expire_pulse_q;
`ifdef DOOR_WARN_EN
    localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN_TICKS);
    logic warn_q;
    // computed from next-state values so warn changes in the same cycle as remaining
    always_ff @(posedge C_100Mhz) begin
        if (restart) warn_q <= 1'b0;
        else warn_q <= (state_d == RUN) && (remaining_d != '0) && (remaining_d <= WARN_V);
    end
    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif
endmodule

// File: tb/tb_door_timer_divider.sv
// tb_door_timer_divider: directed and randomized checks of door_timer_divider against a tick-level reference model.
module tb_door_timer_divider;
    localparam int CLK_HZ = 8, TICK_HZ = 1, P = CLK_HZ / TICK_HZ, CNT_W = 8, WARN_TICKS = 3;
`ifdef DOOR_WARN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic restart = 1'b1, start = 1'b0, retrigger = 1'b0, hold = 1'b0, periodic = 1'b0, ack = 1'b0;
    logic [CNT_W-1:0] timeout_ticks = '0;
    logic tick_sq, tick_pulse, running, expired, expire_pulse, warn;
    logic [CNT_W-1:0] remaining;
    int tests = 0, fails = 0;
    int m_phase = 0, m_rem = 0, m_reload = 0;
    bit m_run = 0, m_exp = 0, m_pulse = 0, m_warn = 0;
    always #5 clk = ~clk;
    door_timer_divider #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CNT_W(CNT_W), .WARN_TICKS(WARN_TICKS)) dut (
        .C_100Mhz(clk),
        .restart(restart),
        .start(start),
        .retrigger(retrigger),
        .hold(hold),
        .periodic(periodic),
        .ack(ack),
        .timeout_ticks(timeout_ticks),
        .tick_sq(tick_sq),
        .tick_pulse(tick_pulse),
        .running(running),
        .remaining(remaining),
        .expired(expired),
        .expire_pulse(expire_pulse),
        .warn(warn)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // m_phase = cycles since the tick period began; a tick is due in its last cycle
    task automatic model_edge();
        bit tick, clr;
        if (restart) begin
            m_phase = 0; m_run = 0; m_rem = 0; m_reload = 0; m_exp = 0; m_pulse = 0;
        end else begin
            tick = (m_phase == P - 1);
            clr = start || (retrigger && m_run);
            m_pulse = 0;
            if (ack) m_exp = 0;
            if (start) begin
                m_reload = (timeout_ticks == 0) ? 1 : int'(timeout_ticks);
                m_rem = m_reload;
                m_run = 1;
                m_exp = 0;
            end else if (retrigger && m_run) begin
                m_rem = m_reload;
            end else if (m_run && tick && !hold) begin
                if (m_rem > 1) m_rem--;
                else begin
                    m_pulse = 1;
                    m_exp = 1;
                    m_rem = periodic ? m_reload : 0;
                    m_run = periodic;
                end
            end
            m_phase = clr ? 0 : (m_phase + 1) % P;
        end
        m_warn = WARN_EN && m_run && m_rem != 0 && m_rem <= WARN_TICKS;
    endtask
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("tick_sq", tick_sq, m_phase < P / 2);
        chk("tick_pulse", tick_pulse, m_phase == P - 1);
        chk("running", running, m_run);
        chk("remaining", remaining, m_rem);
        chk("expired", expired, m_exp);
        chk("expire_pulse", expire_pulse, m_pulse);
        chk("warn", warn, m_warn);
    endtask
    task automatic wait_pulse(input string tag, input int base, input int expect_n);
        int n = -1;
        for (int i = base; i < base + 64; i++) begin
            step();
            if (expire_pulse === 1'b1) begin
                n = i;
                break;
            end
        end
        chk(tag, n, expect_n);
    endtask
    initial begin
        int n_pulse, n_tog, n;
        logic prev_sq;
        restart = 1'b1;
        step();
        step();
        chk("rst_tick_sq", tick_sq, 1);
        chk("rst_running", running, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_expired", expired, 0);
        chk("rst_expire_pulse", expire_pulse, 0);
        chk("rst_warn", warn, 0);
        restart = 1'b0;
        n_pulse = 0;
        n_tog = 0;
        prev_sq = tick_sq;
        repeat (16) begin
            step();
            n_pulse += int'(tick_pulse);
            n_tog += int'(tick_sq != prev_sq);
            prev_sq = tick_sq;
        end
        chk("tick_pulse_count", n_pulse, 2);
        chk("tick_sq_toggles", n_tog, 4);
        timeout_ticks = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        timeout_ticks = 7;
        wait_pulse("oneshot_latency", 1, 24);
        step();
        chk("oneshot_pulse_width", expire_pulse, 0);
        chk("oneshot_expired", expired, 1);
        chk("oneshot_running", running, 0);
        chk("oneshot_remaining", remaining, 0);
        repeat (3) step();
        chk("oneshot_sticky", expired, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_clear", expired, 0);
        timeout_ticks = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        retrigger = 1'b1;
        step();
        retrigger = 1'b0;
        wait_pulse("retrigger_latency", 21, 44);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        hold = 1'b1;
        repeat (16) step();
        chk("hold_remaining", remaining, 3);
        hold = 1'b0;
        wait_pulse("hold_latency", 24, 40);
        periodic = 1'b1;
        timeout_ticks = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_pulse("periodic_first", 1, 16);
        wait_pulse("periodic_second", 1, 16);
        chk("periodic_running", running, 1);
        repeat (7) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("periodic_ack_mid", expired, 0);
        repeat (7) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_vs_expiry_pulse", expire_pulse, 1);
        chk("ack_vs_expiry", expired, 1);
        periodic = 1'b0;
        wait_pulse("periodic_off", 1, 16);
        chk("periodic_off_running", running, 0);
        timeout_ticks = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_load_remaining", remaining, 1);
        wait_pulse("zero_load_latency", 1, 8);
        timeout_ticks = 5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("warn_low_at_5", warn, 0);
        n = 0;
        while (remaining !== 8'd3 && n < 64) begin
            step();
            n++;
        end
        chk("warn_reach_3", remaining, 3);
        chk("warn_at_3", warn, WARN_EN);
        wait_pulse("warn_expiry", 1, 24);
        chk("warn_after_expiry", warn, 0);
        for (int i = 0; i < 3000; i++) begin
            restart = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 39) == 0);
            retrigger = ($urandom_range(0, 29) == 0);
            ack = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            if ($urandom_range(0, 99) == 0) periodic = ~periodic;
            timeout_ticks = CNT_W'($urandom_range(0, 6));
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
